// File: rtl/fifo_sched_ctrl_if.sv
// Bus bundle for fifo_sched_ctrl: two write sources, the downstream FIFO
// write/read side, and the symbol-rate read status outputs.
interface fifo_sched_ctrl_if #(parameter int WIDTH = 16);
  logic             req0, req1;
  logic [WIDTH-1:0] dat0, dat1;
  logic             gnt0, gnt1;
  logic             run;
  logic             fifo_full, fifo_empty;
  logic             fifo_wEN;
  logic [WIDTH-1:0] fifo_dIn;
  logic             fifo_rEN;
  logic             sym_valid;
  logic             sym_underrun;
  logic [7:0]       underrun_cnt;

  // Block side
  modport slave (
    input  req0, req1, dat0, dat1, run, fifo_full, fifo_empty,
    output gnt0, gnt1, fifo_wEN, fifo_dIn, fifo_rEN, sym_valid,
           sym_underrun, underrun_cnt
  );

  // Environment side (sources + FIFO)
  modport master (
    output req0, req1, dat0, dat1, run, fifo_full, fifo_empty,
    input  gnt0, gnt1, fifo_wEN, fifo_dIn, fifo_rEN, sym_valid,
           sym_underrun, underrun_cnt
  );
endinterface

// File: rtl/fifo_sched_ctrl.sv
// fifo_sched_ctrl: round-robin write arbiter for two sources into a FIFO,
// plus a symbol-rate reader that strobes one read every SYM_DIV cycles
// while running and flags slots that found the FIFO empty.
// Optional feature macro: SCHED_UNDERRUN_CNT_EN builds the saturating
// 8-bit underrun counter; without it underrun_cnt is tied to zero.
module fifo_sched_ctrl #(
  parameter int WIDTH   = 16,
  parameter int SYM_DIV = 4
) (
  input logic              CLK,
  input logic              RST,
  fifo_sched_ctrl_if.slave bus
);
  localparam int            CW   = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SYM_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             last_gnt;   // 1: source 1 was granted last
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] din;
  logic             tick, ren;
  logic             sym_valid, sym_underrun;

  // Round-robin grant; nothing is granted in reset or while the FIFO is full
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (RST && !bus.fifo_full) begin
      if (bus.req0 && bus.req1) begin
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  // Write data mux, zero when no source is granted
  always_comb begin
    din = '0;
    if (gnt0)      din = bus.dat0;
    else if (gnt1) din = bus.dat1;
  end

  // Last-grant pointer moves only when a grant is actually issued
  always_ff @(posedge CLK) begin
    if (!RST)      last_gnt <= 1'b1;
    else if (gnt0) last_gnt <= 1'b0;
    else if (gnt1) last_gnt <= 1'b1;
  end

  // Read FSM state register
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Read FSM next state: follow run
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.run)  state_nxt = RUN;
      RUN:     if (!bus.run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slot counter: counts while staying in RUN, otherwise parked at zero
  always_ff @(posedge CLK) begin
    if (!RST)                        cnt <= '0;
    else if (state == RUN && bus.run) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    else                             cnt <= '0;
  end

  assign tick = RST && (state == RUN) && (cnt == LAST);
  assign ren  = tick && !bus.fifo_empty;

  // Read data valid follows the strobe; empty slots flag an underrun
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sym_valid    <= 1'b0;
      sym_underrun <= 1'b0;
    end else begin
      sym_valid    <= ren;
      sym_underrun <= tick && bus.fifo_empty;
    end
  end

`ifdef SCHED_UNDERRUN_CNT_EN
  logic [7:0] ucnt;

  // Saturating count of underrun pulses
  always_ff @(posedge CLK) begin
    if (!RST)                             ucnt <= '0;
    else if (sym_underrun && ucnt != 8'hFF) ucnt <= ucnt + 8'd1;
  end

  assign bus.underrun_cnt = ucnt;
`else
  assign bus.underrun_cnt = '0;
`endif

  assign bus.gnt0         = gnt0;
  assign bus.gnt1         = gnt1;
  assign bus.fifo_wEN     = gnt0 | gnt1;
  assign bus.fifo_dIn     = din;
  assign bus.fifo_rEN     = ren;
  assign bus.sym_valid    = sym_valid;
  assign bus.sym_underrun = sym_underrun;
endmodule

// File: doc/fifo_sched_ctrl.md
FIFO_SCHED_CTRL -- requirements
Module: fifo_sched_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the sample width in bits.
REQ-002 The block SHALL have parameter SYM_DIV, default 4, the clock cycles per symbol slot (legal range 1..256).
REQ-003 Port CLK  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  is the reset, synchronous and active-low.
REQ-005 Ports req0/req1  input  1  are the write requests from source 0 and source 1.
REQ-006 Ports dat0/dat1  input  WIDTH  are the write data from source 0 and source 1.
REQ-007 Ports gnt0/gnt1  output  1  are the combinational grants; data is accepted in the cycle a grant is high.
REQ-008 Port run  input  1  enables symbol-rate reading.
REQ-009 Ports fifo_full/fifo_empty  input  1  are the flags from the downstream synchronous FIFO.
REQ-010 Port fifo_wEN  output  1  and port fifo_dIn  output  WIDTH  drive the FIFO write side.
REQ-011 Port fifo_rEN  output  1  drives the FIFO read strobe.
REQ-012 Port sym_valid  output  1  marks FIFO dOut valid, one cycle after fifo_rEN.
REQ-013 Port sym_underrun  output  1  pulses for a slot that found the FIFO empty.
REQ-014 Port underrun_cnt  output  8  is the saturating underrun count.

Function
REQ-015 Write arbitration SHALL be round-robin: with both requests high, the source not granted last wins; with one request high, that source wins.
REQ-016 No grant SHALL be issued while fifo_full=1; gnt0 and gnt1 SHALL never be high together.
REQ-017 fifo_wEN SHALL equal gnt0|gnt1, and fifo_dIn SHALL equal the granted source's data (zero when idle), combinationally with zero latency.
REQ-018 The last-grant pointer SHALL update only on a grant.
REQ-019 The read FSM SHALL have two states, IDLE and RUN: IDLE->RUN when run=1; RUN->IDLE when run=0.
REQ-020 In IDLE the slot counter SHALL be held at 0; in RUN it SHALL count 0..SYM_DIV-1 and wrap; a slot tick occurs on the cycle where the count equals SYM_DIV-1.
REQ-021 With SYM_DIV=1 a tick SHALL occur on every RUN cycle.
REQ-022 On a tick with fifo_empty=0, fifo_rEN SHALL be 1 for exactly that cycle; at all other times it SHALL be 0.
REQ-023 sym_valid SHALL be fifo_rEN registered one cycle; a pending sym_valid SHALL still assert if run drops.
REQ-024 On a tick with fifo_empty=1, no read SHALL occur, and sym_underrun SHALL pulse high for one cycle on the next cycle.
REQ-025 Write and read paths SHALL be independent; a same-cycle grant and read are legal.

Reset
REQ-026 While RST=0 at a clock edge, the block SHALL load: FSM=IDLE, slot counter=0, last-grant=source 1 (so source 0 wins first), sym_valid=0, sym_underrun=0, underrun_cnt=0.
REQ-027 Reset SHALL abort mid-slot counting; no read SHALL issue in the cycle after reset.
REQ-028 The grant outputs SHALL be low while RST=0.

Configuration
REQ-029 Macro SCHED_UNDERRUN_CNT_EN SHALL control the underrun counter.
REQ-030 When SCHED_UNDERRUN_CNT_EN is defined, underrun_cnt SHALL increment on each sym_underrun pulse and saturate at 255.
REQ-031 When SCHED_UNDERRUN_CNT_EN is undefined, underrun_cnt SHALL be a constant 0 and no counter SHALL be built; sym_underrun is unaffected.

Verification
REQ-032 Both sources request continuously, FIFO not full, for 6 cycles -> grants alternate 0,1,0,1,0,1, and fifo_dIn matches each granted source.
REQ-033 fifo_full=1 with req0=1 -> gnt0=0 and fifo_wEN=0; full drops -> gnt0=1 in the same cycle.
REQ-034 SYM_DIV=4, run=1, FIFO non-empty -> fifo_rEN on cycles 4, 8 and 12 after run rises, with sym_valid one cycle later each time.
REQ-035 run=1 with FIFO empty for 300 slots -> 300 sym_underrun pulses and no fifo_rEN; underrun_cnt=255 with the macro and 0 without it.
REQ-036 RST=0 asserted at slot count 2, then released -> outputs at reset values, and the first read occurs SYM_DIV cycles after the RUN re-entry.
